// File: rtl/uart_word_bridge_pkg.sv
// Shared definitions for the UART word bridge: FSM encodings and parameter defaults.
// The optional RX partial-word timeout is enabled by defining UART_BRIDGE_TIMEOUT_EN.
package uart_word_bridge_pkg;

    localparam int DEF_DATA_BITS      = 8;
    localparam int DEF_WORD_BYTES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1000000;

    typedef enum logic {
        RX_COLLECT = 1'b0,
        RX_HOLD    = 1'b1
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Width of a byte-lane counter for a word of word_bytes lanes.
    function automatic int cnt_width(input int word_bytes);
        return (word_bytes > 1) ? $clog2(word_bytes) : 1;
    endfunction

endpackage

// File: rtl/uart_word_serializer.sv
// TX half of the UART word bridge: latches a word and pushes it LSB byte first
// into the UART TX FIFO, stalling on tx_full.
module uart_word_serializer
    import uart_word_bridge_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int WORD_BYTES = DEF_WORD_BYTES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_BITS*WORD_BYTES-1:0] tx_word,
    input  logic                            tx_word_valid,
    output logic                            tx_word_ready,
    output logic [DATA_BITS-1:0]            uart_w_data,
    output logic                            uart_wr,
    input  logic                            uart_tx_full,
    output logic                            tx_busy
);

    localparam int                WORD_WIDTH = DATA_BITS * WORD_BYTES;
    localparam int                CNT_W      = cnt_width(WORD_BYTES);
    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(WORD_BYTES - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_tx_cnt;
    logic                  w_load;
    logic                  w_last_push;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would infer a latch.
    always_comb begin
        w_state_next  = r_state;
        tx_word_ready = 1'b0;
        uart_wr       = 1'b0;
        w_load        = 1'b0;
        w_last_push   = 1'b0;
        case (r_state)
            TX_IDLE: begin
                tx_word_ready = 1'b1;
                w_load        = tx_word_valid;
                if (tx_word_valid) begin
                    w_state_next = TX_SEND;
                end
            end
            TX_SEND: begin
                uart_wr     = !uart_tx_full;
                w_last_push = !uart_tx_full && (r_tx_cnt == LAST_BYTE);
                if (w_last_push) begin
                    w_state_next = TX_IDLE;
                end
            end
            default: w_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift  <= '0;
            r_tx_cnt <= '0;
        end else if (w_load) begin
            r_shift  <= tx_word;
            r_tx_cnt <= '0;
        end else if (uart_wr) begin
            // The final byte is not shifted out so uart_w_data keeps it while idle.
            if (w_last_push) begin
                r_tx_cnt <= '0;
            end else begin
                r_shift  <= r_shift >> DATA_BITS;
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            end
        end
    end

    assign uart_w_data = r_shift[DATA_BITS-1:0];
    assign tx_busy     = (r_state == TX_SEND);

endmodule

// File: rtl/uart_word_bridge.sv
// Bridges the UART FIFO byte interface to word-wide valid/ready streams (LSB byte first).
// Define UART_BRIDGE_TIMEOUT_EN to discard partial RX words after TIMEOUT_CYCLES idle clocks.
module uart_word_bridge
    import uart_word_bridge_pkg::*;
#(
    parameter int  DATA_BITS      = DEF_DATA_BITS,
    parameter int  WORD_BYTES     = DEF_WORD_BYTES,
    parameter int  TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int WORD_WIDTH     = DATA_BITS * WORD_BYTES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_BITS-1:0]  uart_r_data,
    input  logic                  uart_rx_empty,
    output logic                  uart_rd,
    output logic [DATA_BITS-1:0]  uart_w_data,
    output logic                  uart_wr,
    input  logic                  uart_tx_full,
    output logic [WORD_WIDTH-1:0] rx_word,
    output logic                  rx_word_valid,
    input  logic                  rx_word_ready,
    input  logic [WORD_WIDTH-1:0] tx_word,
    input  logic                  tx_word_valid,
    output logic                  tx_word_ready,
    output logic                  tx_busy,
    output logic                  rx_timeout
);

    localparam int               CNT_W   = cnt_width(WORD_BYTES);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(WORD_BYTES - 1);

    if (WORD_BYTES < 2 || WORD_BYTES > 8 || DATA_BITS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_word_bridge: WORD_BYTES must be 2..8, DATA_BITS and TIMEOUT_CYCLES positive");
    end

    rx_state_t             r_rx_state;
    rx_state_t             w_rx_state_next;
    logic [CNT_W-1:0]      r_rx_cnt;
    logic [WORD_WIDTH-1:0] r_rx_word;
    logic                  w_pop;
    logic                  w_rx_done;
    logic                  w_timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RX_COLLECT;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    // The pop strobe is gated by reset so a held reset never drains the FIFO.
    always_comb begin
        w_rx_state_next = r_rx_state;
        w_pop           = 1'b0;
        w_rx_done       = 1'b0;
        case (r_rx_state)
            RX_COLLECT: begin
                w_pop     = reset && !uart_rx_empty;
                w_rx_done = w_pop && (r_rx_cnt == RX_LAST);
                if (w_rx_done) begin
                    w_rx_state_next = RX_HOLD;
                end
            end
            RX_HOLD: begin
                if (rx_word_ready) begin
                    w_rx_state_next = RX_COLLECT;
                end
            end
            default: w_rx_state_next = RX_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_cnt  <= '0;
            r_rx_word <= '0;
        end else if (w_pop) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (r_rx_cnt == CNT_W'(b)) begin
                    r_rx_word[b*DATA_BITS +: DATA_BITS] <= uart_r_data;
                end
            end
            r_rx_cnt <= w_rx_done ? '0 : r_rx_cnt + CNT_W'(1);
        end else if (w_timeout_hit) begin
            r_rx_cnt <= '0;
        end
    end

    assign uart_rd       = w_pop;
    assign rx_word       = r_rx_word;
    assign rx_word_valid = (r_rx_state == RX_HOLD);

`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_rx_timeout;
    logic              w_idle_run;

    // Idle time is only measured while a partial word is pending.
    assign w_idle_run    = (r_rx_state == RX_COLLECT) && (r_rx_cnt != '0) && !w_pop;
    assign w_timeout_hit = w_idle_run && (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt   <= '0;
            r_rx_timeout <= 1'b0;
        end else begin
            r_rx_timeout <= w_timeout_hit;
            if (!w_idle_run || w_timeout_hit) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
        end
    end

    assign rx_timeout = r_rx_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign rx_timeout    = 1'b0;
`endif

    uart_word_serializer #(
        .DATA_BITS  (DATA_BITS),
        .WORD_BYTES (WORD_BYTES)
    ) u_serializer (
        .clk           (clk),
        .reset         (reset),
        .tx_word       (tx_word),
        .tx_word_valid (tx_word_valid),
        .tx_word_ready (tx_word_ready),
        .uart_w_data   (uart_w_data),
        .uart_wr       (uart_wr),
        .uart_tx_full  (uart_tx_full),
        .tx_busy       (tx_busy)
    );

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: RX assembly, backpressure, TX serialization,
// TX stall, mid-operation reset and partial-word handling (UART_BRIDGE_TIMEOUT_EN aware).
`timescale 1ns/1ps
module tb_uart_word_bridge;

    localparam int DATA_BITS      = 8;
    localparam int WORD_BYTES     = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int WORD_WIDTH     = DATA_BITS * WORD_BYTES;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [DATA_BITS-1:0]  uart_r_data = '0;
    logic                  uart_rx_empty = 1'b1;
    logic                  uart_rd;
    logic [DATA_BITS-1:0]  uart_w_data;
    logic                  uart_wr;
    logic                  uart_tx_full;
    logic [WORD_WIDTH-1:0] rx_word;
    logic                  rx_word_valid;
    logic                  rx_word_ready;
    logic [WORD_WIDTH-1:0] tx_word;
    logic                  tx_word_valid;
    logic                  tx_word_ready;
    logic                  tx_busy;
    logic                  rx_timeout;

    uart_word_bridge #(
        .DATA_BITS      (DATA_BITS),
        .WORD_BYTES     (WORD_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_r_data   (uart_r_data),
        .uart_rx_empty (uart_rx_empty),
        .uart_rd       (uart_rd),
        .uart_w_data   (uart_w_data),
        .uart_wr       (uart_wr),
        .uart_tx_full  (uart_tx_full),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .rx_word_ready (rx_word_ready),
        .tx_word       (tx_word),
        .tx_word_valid (tx_word_valid),
        .tx_word_ready (tx_word_ready),
        .tx_busy       (tx_busy),
        .rx_timeout    (rx_timeout)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] pop_log[$];
    logic [7:0] tx_log[$];
    int rd_viol        = 0;
    int wr_viol        = 0;
    int timeout_pulses = 0;
    int n_checks       = 0;
    int n_errors       = 0;

    // RX FIFO model and TX FIFO sink; FIFO head/empty refresh 1 ns after each edge.
    always @(posedge clk) begin
        if (uart_rd) begin
            if (uart_rx_empty || rx_q.size() == 0) rd_viol++;
            else pop_log.push_back(rx_q.pop_front());
        end
        if (uart_wr) begin
            if (uart_tx_full) wr_viol++;
            tx_log.push_back(uart_w_data);
        end
        if (rx_timeout) timeout_pulses++;
        #1;
        uart_rx_empty = (rx_q.size() == 0);
        uart_r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input int nbytes);
        for (int i = 0; i < nbytes; i++) rx_q.push_back(w[i*8 +: 8]);
    endtask

    function automatic logic [31:0] tx_log_word();
        logic [31:0] w = '0;
        for (int i = 0; i < tx_log.size() && i < 4; i++) w[i*8 +: 8] = tx_log[i];
        return w;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_uart_rd"},       uart_rd,       1'b0);
        check({pfx, "_uart_wr"},       uart_wr,       1'b0);
        check({pfx, "_uart_w_data"},   uart_w_data,   8'h00);
        check({pfx, "_rx_word"},       rx_word,       32'h0);
        check({pfx, "_rx_word_valid"}, rx_word_valid, 1'b0);
        check({pfx, "_tx_word_ready"}, tx_word_ready, 1'b1);
        check({pfx, "_tx_busy"},       tx_busy,       1'b0);
        check({pfx, "_rx_timeout"},    rx_timeout,    1'b0);
    endtask

    task automatic wait_rx_valid(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (!rx_word_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_arrived"}, rx_word_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b[4];
        logic [7:0] loop_b[$];
        int wr_seen;
        int valid_seen;
        int n;

        reset         = 1'b0;
        tx_word       = '0;
        tx_word_valid = 1'b0;
        rx_word_ready = 1'b1;
        uart_tx_full  = 1'b0;
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;

        // Power-on reset with a byte waiting: nothing may be popped.
        rx_q.push_back(8'h99);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        check("por_no_pop", pop_log.size(), 0);
        rx_q.delete();
        @(negedge clk);
        reset = 1'b1;

        // Basic RX: four consecutive pops, valid the cycle after the last pop.
        push_word(32'h44332211, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rx_basic_rd%0d", i), uart_rd, 1'b1);
            check($sformatf("rx_basic_novalid%0d", i), rx_word_valid, 1'b0);
        end
        @(negedge clk);
        check("rx_basic_valid", rx_word_valid, 1'b1);
        check("rx_basic_word", rx_word, 32'h44332211);
        check("rx_basic_rd_off", uart_rd, 1'b0);
        check("rx_basic_pops", pop_log.size(), 4);
        @(negedge clk);
        check("rx_basic_accepted", rx_word_valid, 1'b0);

        // RX backpressure: eight bytes queued, consumer not ready.
        rx_word_ready = 1'b0;
        push_word(32'hA4A3A2A1, 4);
        push_word(32'hA8A7A6A5, 4);
        repeat (12) @(negedge clk);
        check("rx_bp_pops_held", pop_log.size(), 8);
        check("rx_bp_rd_off", uart_rd, 1'b0);
        check("rx_bp_valid", rx_word_valid, 1'b1);
        check("rx_bp_word1", rx_word, 32'hA4A3A2A1);
        check("rx_bp_fifo_left", rx_q.size(), 4);
        rx_word_ready = 1'b1;
        wait_rx_valid("rx_bp_word2", 20);
        check("rx_bp_word2", rx_word, 32'hA8A7A6A5);
        check("rx_bp_pops_all", pop_log.size(), 12);
        @(negedge clk);

        // Basic TX: DEADBEEF goes out LSB byte first on consecutive cycles.
        tx_log.delete();
        tx_word       = 32'hDEADBEEF;
        tx_word_valid = 1'b1;
        check("tx_basic_ready_idle", tx_word_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tx_word_valid = 1'b0;
            check($sformatf("tx_basic_wr%0d", i), uart_wr, 1'b1);
            check($sformatf("tx_basic_byte%0d", i), uart_w_data, exp_b[i]);
            check($sformatf("tx_basic_ready_low%0d", i), tx_word_ready, 1'b0);
        end
        @(negedge clk);
        check("tx_basic_ready_back", tx_word_ready, 1'b1);
        check("tx_basic_busy_off", tx_busy, 1'b0);
        check("tx_basic_wr_off", uart_wr, 1'b0);
        check("tx_basic_data_hold", uart_w_data, 8'hDE);
        check("tx_basic_count", tx_log.size(), 4);
        check("tx_basic_log", tx_log_word(), 32'hDEADBEEF);

        // TX stall: full for 10 cycles after the second byte.
        tx_log.delete();
        tx_word_valid = 1'b1;
        @(negedge clk);
        tx_word_valid = 1'b0;
        check("tx_stall_b0", uart_w_data, 8'hEF);
        @(negedge clk);
        check("tx_stall_b1", uart_w_data, 8'hBE);
        @(negedge clk);
        check("tx_stall_head", uart_w_data, 8'hAD);
        uart_tx_full = 1'b1;
        wr_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (uart_wr) wr_seen++;
        end
        check("tx_stall_no_wr", wr_seen, 0);
        check("tx_stall_busy", tx_busy, 1'b1);
        check("tx_stall_held_data", uart_w_data, 8'hAD);
        check("tx_stall_held_count", tx_log.size(), 2);
        uart_tx_full = 1'b0;
        #1;
        check("tx_stall_resume_wr", uart_wr, 1'b1);
        @(negedge clk);
        check("tx_stall_last_byte", uart_w_data, 8'hDE);
        @(negedge clk);
        check("tx_stall_ready_back", tx_word_ready, 1'b1);
        check("tx_stall_count", tx_log.size(), 4);
        check("tx_stall_log", tx_log_word(), 32'hDEADBEEF);

        // Reset after two RX pops and one TX push.
        pop_log.delete();
        tx_log.delete();
        push_word(32'h8D7C6B5A, 4);
        @(negedge clk);
        tx_word       = 32'h12345678;
        tx_word_valid = 1'b1;
        @(negedge clk);
        tx_word_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        check("mid_rst_pops", pop_log.size(), 2);
        check("mid_rst_pushes", tx_log.size(), 1);
        repeat (3) @(negedge clk);
        check("mid_rst_no_more_pops", pop_log.size(), 2);
        check("mid_rst_no_more_pushes", tx_log.size(), 1);
        rx_q.delete();
        @(negedge clk);
        reset = 1'b1;

        // Loopback of A5A5A5A5 through TX and back through RX.
        tx_log.delete();
        tx_word       = 32'hA5A5A5A5;
        tx_word_valid = 1'b1;
        @(negedge clk);
        tx_word_valid = 1'b0;
        n = 0;
        while (tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("loop_tx_done", tx_busy, 1'b0);
        check("loop_tx_count", tx_log.size(), 4);
        loop_b = tx_log;
        foreach (loop_b[i]) rx_q.push_back(loop_b[i]);
        wait_rx_valid("loop_rx", 20);
        check("loop_rx_word", rx_word, 32'hA5A5A5A5);
        @(negedge clk);

        // Partial word left idle.
        pop_log.delete();
        timeout_pulses = 0;
        valid_seen     = 0;
        push_word(32'h00008877, 2);
        repeat (30) begin
            @(negedge clk);
            if (rx_word_valid) valid_seen++;
        end
        check("partial_pops", pop_log.size(), 2);
        check("partial_no_valid", valid_seen, 0);
`ifdef UART_BRIDGE_TIMEOUT_EN
        check("timeout_pulses", timeout_pulses, 1);
        push_word(32'h04030201, 4);
        wait_rx_valid("timeout_next", 20);
        check("timeout_next_word", rx_word, 32'h04030201);
`else
        check("no_timeout_pulses", timeout_pulses, 0);
        push_word(32'h00000403, 2);
        wait_rx_valid("partial_resume", 20);
        check("partial_resume_word", rx_word, 32'h04038877);
`endif
        @(negedge clk);

        check("rd_while_empty", rd_viol, 0);
        check("wr_while_full", wr_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
